reg_writeback: RTL and testbench

//  Write side of the register file: queues ALU results (dest reg + data) and drives the

---
 rtl/mips_defs.sv | 24 ++
 rtl/reg_writeback_if.sv | 43 ++++
 rtl/wb_queue.sv | 80 ++++++++
 rtl/reg_writeback.sv | 113 +++++++++++
 tb/tb_reg_writeback.sv | 201 ++++++++++++++++++++
 5 files changed

// File: rtl/mips_defs.sv
`default_nettype none
// +--------------------------------------------------------------+
// | mips_defs: register-file widths and the write-back entry type |
// | Rev 1.0                                                       |
// +--------------------------------------------------------------+
package mips_defs;

  localparam int REG_ADDR_W = 5;
  localparam int REG_DATA_W = 32;
  localparam logic [REG_ADDR_W-1:0] ZERO_REG = 5'd0;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] idx;
    logic [REG_DATA_W-1:0] data;
  } wb_entry_t;

  // Register $zero is hardwired, so it can never be a bypass source.
  function automatic logic reg_hit(input logic [REG_ADDR_W-1:0] entry_idx,
                                   input logic [REG_ADDR_W-1:0] read_idx);
    return (entry_idx == read_idx) && (read_idx != ZERO_REG);
  endfunction

endpackage
`default_nettype wire

// File: rtl/reg_writeback_if.sv
`default_nettype none
// +--------------------------------------------------------------+
// | reg_writeback_if: ALU result, register-file write, bypass bus |
// | Rev 1.0                                                       |
// +--------------------------------------------------------------+
interface reg_writeback_if #(
  parameter int DEPTH  = 2,
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
);
  localparam int c_CNT_W = $clog2(DEPTH) + 1;

  logic              RES_VALID;
  logic              RES_READY;
  logic [ADDR_W-1:0] RES_REG;
  logic [DATA_W-1:0] RES_DATA;
  logic              WB_EN;
  logic              FLUSH;
  logic              RegWrite;
  logic [ADDR_W-1:0] WriteReg;
  logic [DATA_W-1:0] WriteData;
  logic [ADDR_W-1:0] ReadReg1;
  logic [ADDR_W-1:0] ReadReg2;
  logic              FWD_A_HIT;
  logic [DATA_W-1:0] FWD_A_DATA;
  logic              FWD_B_HIT;
  logic [DATA_W-1:0] FWD_B_DATA;
  logic [c_CNT_W-1:0] PENDING;

  modport master (
    output RES_VALID, RES_REG, RES_DATA, WB_EN, FLUSH, ReadReg1, ReadReg2,
    input  RES_READY, RegWrite, WriteReg, WriteData,
           FWD_A_HIT, FWD_A_DATA, FWD_B_HIT, FWD_B_DATA, PENDING
  );

  modport slave (
    input  RES_VALID, RES_REG, RES_DATA, WB_EN, FLUSH, ReadReg1, ReadReg2,
    output RES_READY, RegWrite, WriteReg, WriteData,
           FWD_A_HIT, FWD_A_DATA, FWD_B_HIT, FWD_B_DATA, PENDING
  );

endinterface
`default_nettype wire

// File: rtl/wb_queue.sv
`default_nettype none
// +--------------------------------------------------------------+
// | wb_queue: sync FIFO of wb_entry_t with flush, slot visibility |
// | Rev 1.0                                                       |
// +--------------------------------------------------------------+
module wb_queue
  import mips_defs::*;
#(
  parameter int DEPTH = 2
) (
  input  wire logic                          CLK,
  input  wire logic                          RESET,
  input  wire logic                          i_push,
  input  wire logic                          i_pop,
  input  wire logic                          i_flush,
  input  wire wb_entry_t                     i_din,
  output wb_entry_t                          o_head,
  output logic [$clog2(DEPTH):0]             o_count,
  output wb_entry_t [DEPTH-1:0]              o_entries,
  output logic [DEPTH-1:0]                   o_valid,
  output logic [$clog2(DEPTH)-1:0]           o_wr_ptr
);

  localparam int c_PTR_W = $clog2(DEPTH);
  localparam int c_CNT_W = c_PTR_W + 1;

  wb_entry_t          r_mem [DEPTH];
  logic [c_PTR_W-1:0] r_wr_ptr;
  logic [c_PTR_W-1:0] r_rd_ptr;
  logic [c_CNT_W-1:0] r_count;
  logic [DEPTH-1:0]   r_valid;
  logic [DEPTH-1:0]   w_valid_nxt;
  logic               w_do_push;
  logic               w_do_pop;

  // A full queue refuses a push even when a pop frees a slot on the same edge.
  assign w_do_push = i_push && !i_flush && (r_count < c_CNT_W'(DEPTH));
  assign w_do_pop  = i_pop  && !i_flush && (r_count != '0);

  always_comb begin
    w_valid_nxt = r_valid;
    if (w_do_pop)  w_valid_nxt[r_rd_ptr] = 1'b0;
    if (w_do_push) w_valid_nxt[r_wr_ptr] = 1'b1;
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_valid  <= '0;
    end else if (i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_valid  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
      if (w_do_push && !w_do_pop)      r_count <= r_count + c_CNT_W'(1);
      else if (!w_do_push && w_do_pop) r_count <= r_count - c_CNT_W'(1);
      r_valid <= w_valid_nxt;
    end
  end

  always_ff @(posedge CLK) begin
    if (w_do_push) r_mem[r_wr_ptr] <= i_din;
  end

  for (genvar i = 0; i < DEPTH; i++) begin : g_slot
    assign o_entries[i] = r_mem[i];
  end

  assign o_head   = r_mem[r_rd_ptr];
  assign o_count  = r_count;
  assign o_valid  = r_valid;
  assign o_wr_ptr = r_wr_ptr;

endmodule
`default_nettype wire

// File: rtl/reg_writeback.sv
`default_nettype none
// +--------------------------------------------------------------+
// | reg_writeback: queues ALU results into the register file port |
// | and bypasses pending values to decode reads.  Rev 1.0          |
// +--------------------------------------------------------------+
module reg_writeback
  import mips_defs::*;
#(
  parameter int DEPTH  = 2,
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input wire logic      CLK,
  input wire logic      RESET,
  reg_writeback_if.slave bus
);

  localparam int c_PTR_W = $clog2(DEPTH);
  localparam int c_CNT_W = c_PTR_W + 1;

  wb_entry_t              w_push_entry;
  wb_entry_t              w_head;
  wb_entry_t [DEPTH-1:0]  w_entries;
  logic [DEPTH-1:0]       w_valid;
  logic [c_PTR_W-1:0]     w_wr_ptr;
  logic [c_CNT_W-1:0]     w_count;
  logic                   w_accept;
  logic                   w_push;
  logic                   w_pop;
  logic [DATA_W:0]        w_fwd_a;
  logic [DATA_W:0]        w_fwd_b;

  logic                   r_reg_write;
  logic [ADDR_W-1:0]      r_write_reg;
  logic [DATA_W-1:0]      r_write_data;

  assign bus.RES_READY = RESET && (w_count < c_CNT_W'(DEPTH));
  assign w_accept      = bus.RES_VALID && bus.RES_READY;
  // Writes to $zero complete the handshake but are dropped here.
  assign w_push        = w_accept && (bus.RES_REG != ZERO_REG);
  assign w_pop         = bus.WB_EN && (w_count != '0) && !bus.FLUSH;
  assign w_push_entry  = '{idx: bus.RES_REG, data: bus.RES_DATA};

  wb_queue #(
    .DEPTH (DEPTH)
  ) u_queue (
    .CLK       (CLK),
    .RESET     (RESET),
    .i_push    (w_push),
    .i_pop     (w_pop),
    .i_flush   (bus.FLUSH),
    .i_din     (w_push_entry),
    .o_head    (w_head),
    .o_count   (w_count),
    .o_entries (w_entries),
    .o_valid   (w_valid),
    .o_wr_ptr  (w_wr_ptr)
  );

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      r_reg_write  <= 1'b0;
      r_write_reg  <= '0;
      r_write_data <= '0;
    end else begin
      r_reg_write <= w_pop;
      if (w_pop) begin
        r_write_reg  <= w_head.idx;
        r_write_data <= w_head.data;
      end
    end
  end

  // Later assignments override earlier ones, so the scan runs lowest priority
  // first: output register, then queue slots from oldest to youngest.
  function automatic logic [DATA_W:0] bypass(input logic [ADDR_W-1:0] rd_idx);
    logic               hit;
    logic [DATA_W-1:0]  data;
    logic [c_PTR_W-1:0] slot;
    hit  = 1'b0;
    data = '0;
    if (r_reg_write && reg_hit(r_write_reg, rd_idx)) begin
      hit  = 1'b1;
      data = r_write_data;
    end
    for (int k = DEPTH; k >= 1; k--) begin
      slot = w_wr_ptr - c_PTR_W'(k);
      if (w_valid[slot] && reg_hit(w_entries[slot].idx, rd_idx)) begin
        hit  = 1'b1;
        data = w_entries[slot].data;
      end
    end
    return {hit, data};
  endfunction

  always_comb begin
    w_fwd_a = '0;
    w_fwd_b = '0;
    w_fwd_a = bypass(bus.ReadReg1);
    w_fwd_b = bypass(bus.ReadReg2);
  end

  assign bus.FWD_A_HIT  = w_fwd_a[DATA_W];
  assign bus.FWD_A_DATA = w_fwd_a[DATA_W-1:0];
  assign bus.FWD_B_HIT  = w_fwd_b[DATA_W];
  assign bus.FWD_B_DATA = w_fwd_b[DATA_W-1:0];
  assign bus.RegWrite   = r_reg_write;
  assign bus.WriteReg   = r_write_reg;
  assign bus.WriteData  = r_write_data;
  assign bus.PENDING    = w_count;

endmodule
`default_nettype wire

// File: tb/tb_reg_writeback.sv
`default_nettype none
// +--------------------------------------------------------------+
// | tb_reg_writeback: directed self-checking bench for writeback  |
// | Rev 1.0                                                       |
// +--------------------------------------------------------------+
module tb_reg_writeback;

  logic CLK   = 1'b0;
  logic RESET = 1'b0;
  int   checks   = 0;
  int   failures = 0;

  reg_writeback_if #(.DEPTH(2), .DATA_W(32), .ADDR_W(5)) bus ();

  reg_writeback #(.DEPTH(2), .DATA_W(32), .ADDR_W(5)) dut (
    .CLK   (CLK),
    .RESET (RESET),
    .bus   (bus)
  );

  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus.RES_VALID = 1'b0;
    bus.RES_REG   = '0;
    bus.RES_DATA  = '0;
    bus.WB_EN     = 1'b0;
    bus.FLUSH     = 1'b0;
    bus.ReadReg1  = '0;
    bus.ReadReg2  = '0;

    // Power-on reset
    repeat (2) tick();
    check("rst_regwrite",  bus.RegWrite,  0);
    check("rst_writereg",  bus.WriteReg,  0);
    check("rst_writedata", bus.WriteData, 0);
    check("rst_pending",   bus.PENDING,   0);
    check("rst_ready",     bus.RES_READY, 0);
    check("rst_fwd_a",     bus.FWD_A_HIT, 0);
    RESET = 1'b1;
    tick();
    check("rel_ready",     bus.RES_READY, 1);

    // Single write: accepted at edge 1, written after edge 2
    bus.WB_EN = 1'b1; bus.RES_VALID = 1'b1; bus.RES_REG = 5'd2; bus.RES_DATA = 32'h5;
    tick();
    bus.RES_VALID = 1'b0;
    check("sw_pend1",      bus.PENDING,   1);
    check("sw_rw_early",   bus.RegWrite,  0);
    tick();
    check("sw_regwrite",   bus.RegWrite,  1);
    check("sw_writereg",   bus.WriteReg,  2);
    check("sw_writedata",  bus.WriteData, 32'h5);
    check("sw_pend0",      bus.PENDING,   0);
    tick();
    check("sw_rw_drop",    bus.RegWrite,  0);

    // Stall until full, third push held, then drain 3,4,5 back to back
    bus.WB_EN = 1'b0; bus.RES_VALID = 1'b1; bus.RES_REG = 5'd3; bus.RES_DATA = 32'hA;
    tick();
    bus.RES_REG = 5'd4; bus.RES_DATA = 32'hB;
    tick();
    bus.RES_REG = 5'd5; bus.RES_DATA = 32'hC;
    #1;
    check("full_pending",  bus.PENDING,   2);
    check("full_ready",    bus.RES_READY, 0);
    tick();
    check("held_pending",  bus.PENDING,   2);
    check("held_rw",       bus.RegWrite,  0);
    bus.WB_EN = 1'b1;
    tick();
    check("drain1_reg",    bus.WriteReg,  3);
    check("drain1_data",   bus.WriteData, 32'hA);
    check("drain1_pend",   bus.PENDING,   1);
    tick();
    bus.RES_VALID = 1'b0;
    check("drain2_rw",     bus.RegWrite,  1);
    check("drain2_reg",    bus.WriteReg,  4);
    check("drain2_data",   bus.WriteData, 32'hB);
    check("drain2_pend",   bus.PENDING,   1);
    tick();
    check("drain3_rw",     bus.RegWrite,  1);
    check("drain3_reg",    bus.WriteReg,  5);
    check("drain3_data",   bus.WriteData, 32'hC);
    check("drain3_pend",   bus.PENDING,   0);
    tick();
    check("drain_end_rw",  bus.RegWrite,  0);

    // Zero register: handshake completes, nothing queued or written
    bus.RES_VALID = 1'b1; bus.RES_REG = 5'd0; bus.RES_DATA = 32'hFFFF_FFFF; bus.ReadReg1 = 5'd0;
    #1;
    check("zero_ready",    bus.RES_READY, 1);
    tick();
    bus.RES_VALID = 1'b0;
    check("zero_pending",  bus.PENDING,   0);
    check("zero_fwd_a",    bus.FWD_A_HIT, 0);
    tick();
    check("zero_rw",       bus.RegWrite,  0);

    // Bypass: youngest queued entry wins, then output register
    bus.WB_EN = 1'b0; bus.RES_VALID = 1'b1; bus.RES_REG = 5'd5; bus.RES_DATA = 32'h1;
    tick();
    bus.RES_DATA = 32'h2;
    tick();
    bus.RES_VALID = 1'b0; bus.ReadReg1 = 5'd5; bus.ReadReg2 = 5'd6;
    #1;
    check("byp_a_hit",     bus.FWD_A_HIT,  1);
    check("byp_a_data",    bus.FWD_A_DATA, 32'h2);
    check("byp_b_hit",     bus.FWD_B_HIT,  0);
    check("byp_b_data",    bus.FWD_B_DATA, 0);
    bus.WB_EN = 1'b1;
    tick();
    check("byp_pop1_data", bus.WriteData,  32'h1);
    check("byp_q_over_or", bus.FWD_A_DATA, 32'h2);
    tick();
    check("byp_or_hit",    bus.FWD_A_HIT,  1);
    check("byp_or_data",   bus.FWD_A_DATA, 32'h2);
    check("byp_or_pend",   bus.PENDING,    0);
    bus.WB_EN = 1'b0;
    tick();
    check("byp_gone_hit",  bus.FWD_A_HIT,  0);
    check("byp_gone_data", bus.FWD_A_DATA, 0);

    // Flush race with a full queue and an active drain
    bus.ReadReg1 = 5'd0; bus.ReadReg2 = 5'd7;
    bus.RES_VALID = 1'b1; bus.RES_REG = 5'd8; bus.RES_DATA = 32'h88;
    tick();
    bus.RES_REG = 5'd9; bus.RES_DATA = 32'h99;
    tick();
    check("fl_pre_pend",   bus.PENDING,   2);
    bus.RES_REG = 5'd7; bus.RES_DATA = 32'h7; bus.FLUSH = 1'b1; bus.WB_EN = 1'b1;
    tick();
    bus.FLUSH = 1'b0; bus.RES_VALID = 1'b0;
    check("fl_pending",    bus.PENDING,   0);
    check("fl_rw",         bus.RegWrite,  0);
    check("fl_ready",      bus.RES_READY, 1);
    check("fl_fwd_b",      bus.FWD_B_HIT, 0);
    tick();
    check("fl_rw_after",   bus.RegWrite,  0);

    // Flush drops a push that the queue had room for
    bus.WB_EN = 1'b0; bus.RES_VALID = 1'b1; bus.RES_REG = 5'd10; bus.RES_DATA = 32'h10;
    tick();
    bus.RES_REG = 5'd7; bus.RES_DATA = 32'h7; bus.FLUSH = 1'b1;
    #1;
    check("fl2_ready",     bus.RES_READY, 1);
    tick();
    bus.FLUSH = 1'b0; bus.RES_VALID = 1'b0; bus.WB_EN = 1'b1;
    check("fl2_pending",   bus.PENDING,   0);
    check("fl2_fwd_b",     bus.FWD_B_HIT, 0);
    tick();
    check("fl2_rw",        bus.RegWrite,  0);

    // Reset mid-stream with two entries pending
    bus.WB_EN = 1'b0; bus.RES_VALID = 1'b1; bus.RES_REG = 5'd11; bus.RES_DATA = 32'hB1;
    bus.ReadReg1 = 5'd12;
    tick();
    bus.RES_REG = 5'd12; bus.RES_DATA = 32'hC2;
    tick();
    check("mr_pre_pend",   bus.PENDING,   2);
    check("mr_pre_fwd",    bus.FWD_A_HIT, 1);
    RESET = 1'b0;
    #1;
    check("mr_pending",    bus.PENDING,   0);
    check("mr_ready",      bus.RES_READY, 0);
    check("mr_rw",         bus.RegWrite,  0);
    check("mr_fwd",        bus.FWD_A_HIT, 0);
    tick();
    check("mr_hold_pend",  bus.PENDING,   0);
    RESET = 1'b1; bus.RES_VALID = 1'b0; bus.WB_EN = 1'b1;
    tick();
    check("mr_rel_ready",  bus.RES_READY, 1);
    check("mr_rel_pend",   bus.PENDING,   0);
    tick();
    check("mr_rel_rw",     bus.RegWrite,  0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
